dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the pipeline MEM stage (port 0) and a secondary requester such as a loader/debug port (port 1). It sits directly in front of the data memory: it drives the memory's address, memwrite, memread and writedata inputs, and registers the memory's read data back to the winning port. Port 0 has fixed priority; a starvation counter guarantees port 1 forward progress.

## Interface

- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive cycles port 1 may lose to port 0 before it is forced a grant (1..15)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  access request, level-sensitive
- p0_address / p1_address  in  AW  byte address
- p0_memwrite / p1_memwrite  in  2  00 none, 01 sw, 10 sb, 11 sh
- p0_memread / p1_memread  in  2  00 none, 01 lw, 10 lb, 11 lh
- p0_writedata / p1_writedata  in  DW  store data
- p0_gnt / p1_gnt  out  1  registered grant; one access completes per high cycle
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse, read data valid
- p0_rdata / p1_rdata  out  DW  registered read data, held until next read on that port
- mem_address  out  AW  to memory
- mem_memwrite  out  2  to memory
- mem_memread  out  2  to memory
- mem_writedata  out  DW  to memory
- mem_read_data  in  DW  combinational read data from memory

## Operation

- States: IDLE, G0 (p0_gnt=1), G1 (p1_gnt=1). Exactly one or zero grants high.
- Next-state decision at each rising edge, from current req levels: force = p1_req and starve_cnt == STARVE_MAX. force -> G1; else p0_req -> G0; else p1_req -> G1; else IDLE.
- Holds for any current state: back-to-back grants to the same port are allowed; a requester keeping req high during its gnt cycle is requesting another access.
- In G0/G1, mem_address, mem_memwrite, mem_memread, mem_writedata are a combinational mux of the granted port's inputs. In IDLE: address/writedata 0, memwrite 00, memread 00.
- Requester must hold address/command/data stable for the whole gnt cycle; it deasserts req within the gnt cycle if it has no further access.
- Command conflict (memwrite != 00 and memread != 00 from granted port): memwrite forwarded, mem_memread forced 00, no rvalid.
- Read capture: at the rising edge ending a gnt cycle with forwarded memread != 00, mem_read_data -> pN_rdata and pN_rvalid=1 for the following cycle. Write or no-op: no rvalid.
- starve_cnt (4 bits): at each edge, if p1_req and next state is G0, increment (saturating at STARVE_MAX); if next state is G1 or p1_req=0, clear to 0.

## Timing

- Reset (asynchronous, immediate): state IDLE, both gnt 0, both rvalid 0, both rdata 0, starve_cnt 0, all mem_* outputs 0. Assertion during a gnt cycle drops mem_memwrite to 00 combinationally, so a pending negedge write is suppressed; no rvalid follows.
- Latency: req first high in cycle n -> gnt in cycle n+1 (uncontended) -> rvalid/rdata in cycle n+2.
- Throughput: one access per cycle; continuous port-0 requests yield STARVE_MAX G0 cycles then one G1 cycle when port 1 is waiting.
- Simultaneous first requests: port 0 wins unless force.
- Port 1 dropping req while waiting clears starve_cnt; no grant is issued to an idle port.
- rvalid on one port and gnt on the other may be high in the same cycle.

## Test plan

- Reset then p0 lw to 0x8, memory holds 0x11223344 there -> p0_gnt cycle 1, mem_memread=01, p0_rvalid cycle 2 with p0_rdata=0x11223344; p1 outputs stay 0.
- p0 and p1 request same cycle (p0 sw 0xAABBCCDD @0x0, p1 lw @0x0) -> G0 then G1; p1_rdata=0xAABBCCDD.
- p0_req held high 10 cycles, p1_req held high, STARVE_MAX=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
- Granted port issues memwrite=01 and memread=01 -> mem_memread=00, write occurs, no rvalid.
- Reset asserted mid-G0 with p0 sw pending -> mem_memwrite=00 immediately, memory word unchanged, all outputs 0.
- No requests for 5 cycles -> IDLE, all mem_* outputs 0, no gnt/rvalid.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the pipeline MEM stage (port 0,
// fixed priority) and a secondary requester (port 1). A starvation counter
// forces a port-1 grant after STARVE_MAX consecutive losses to port 0.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_address,
    input  logic [1:0]    p0_memwrite,
    input  logic [1:0]    p0_memread,
    input  logic [DW-1:0] p0_writedata,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_address,
    input  logic [1:0]    p1_memwrite,
    input  logic [1:0]    p1_memread,
    input  logic [DW-1:0] p1_writedata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [1:0]    mem_memwrite,
    output logic [1:0]    mem_memread,
    output logic [DW-1:0] mem_writedata,
    input  logic [DW-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          force_g1;

    logic          p0_gnt_q, p1_gnt_q;
    logic          p0_rvalid_q, p1_rvalid_q;
    logic [DW-1:0] p0_rdata_q, p1_rdata_q;

    logic [AW-1:0] sel_address;
    logic [1:0]    sel_memwrite;
    logic [1:0]    sel_memread;
    logic [DW-1:0] sel_writedata;
    logic [1:0]    fwd_memread;

    // Next grant decision: forced port-1 grant beats port-0 priority.
    always_comb begin
        force_g1 = p1_req && (starve_q == STARVE_LIM);
        state_d  = IDLE;
        if (force_g1) begin
            state_d = G1;
        end else if (p0_req) begin
            state_d = G0;
        end else if (p1_req) begin
            state_d = G1;
        end

        // Count only losses of a waiting port 1; anything else clears it.
        starve_d = 4'd0;
        if (p1_req && (state_d == G0)) begin
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end
    end

    // Route the granted port's command onto the memory bus; idle bus is all zero.
    always_comb begin
        sel_address   = '0;
        sel_memwrite  = 2'b00;
        sel_memread   = 2'b00;
        sel_writedata = '0;
        case (state_q)
            G0: begin
                sel_address   = p0_address;
                sel_memwrite  = p0_memwrite;
                sel_memread   = p0_memread;
                sel_writedata = p0_writedata;
            end
            G1: begin
                sel_address   = p1_address;
                sel_memwrite  = p1_memwrite;
                sel_memread   = p1_memread;
                sel_writedata = p1_writedata;
            end
            default: ;
        endcase
        // A write and a read in the same command: the write wins, no read.
        fwd_memread = (sel_memwrite != 2'b00) ? 2'b00 : sel_memread;
    end

    // Reset gates the bus combinationally so a write pending on the memory's
    // falling-edge write port is dropped as soon as reset rises.
    assign mem_address   = reset ? '0    : sel_address;
    assign mem_memwrite  = reset ? 2'b00 : sel_memwrite;
    assign mem_memread   = reset ? 2'b00 : fwd_memread;
    assign mem_writedata = reset ? '0    : sel_writedata;

    // Arbiter FSM with registered grants and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            p0_gnt_q    <= 1'b0;
            p1_gnt_q    <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            p0_gnt_q    <= (state_d == G0);
            p1_gnt_q    <= (state_d == G1);
            p0_rvalid_q <= (state_q == G0) && (fwd_memread != 2'b00);
            p1_rvalid_q <= (state_q == G1) && (fwd_memread != 2'b00);
            if ((state_q == G0) && (fwd_memread != 2'b00)) begin
                p0_rdata_q <= mem_read_data;
            end
            if ((state_q == G1) && (fwd_memread != 2'b00)) begin
                p1_rdata_q <= mem_read_data;
            end
        end
    end

    assign p0_gnt    = p0_gnt_q;
    assign p1_gnt    = p1_gnt_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural memory (combinational read,
// falling-edge write), directed stimulus and a per-port read-data scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p1_req;
    logic [31:0] p0_address, p1_address;
    logic [1:0]  p0_memwrite, p1_memwrite, p0_memread, p1_memread;
    logic [31:0] p0_writedata, p1_writedata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_writedata, mem_read_data;
    logic [1:0]  mem_memwrite, mem_memread;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    logic [31:0] mem [0:63];
    logic        preload;
    logic [5:0]  mem_idx;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_address(p0_address), .p0_memwrite(p0_memwrite),
        .p0_memread(p0_memread), .p0_writedata(p0_writedata),
        .p1_req(p1_req), .p1_address(p1_address), .p1_memwrite(p1_memwrite),
        .p1_memread(p1_memread), .p1_writedata(p1_writedata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_writedata(mem_writedata),
        .mem_read_data(mem_read_data)
    );

    // Memory model: word-indexed, combinational read, writes on falling edge.
    assign mem_idx       = mem_address[7:2];
    assign mem_read_data = mem[mem_idx];

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h11223344;
            mem[5] <= 32'h01234567;
        end else begin
            case (mem_memwrite)
                2'b01: mem[mem_idx] <= mem_writedata;
                2'b10: mem[mem_idx][8*mem_address[1:0] +: 8] <= mem_writedata[7:0];
                2'b11: mem[mem_idx][16*mem_address[1] +: 16] <= mem_writedata[15:0];
                default: ;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rvalid pulse must match the oldest expected read on that port.
    always @(posedge clk) begin
        #2;
        if (p0_rvalid) begin
            if (exp_q0.size() == 0) check_eq("p0_unexpected_rvalid", 32'd1, 32'd0);
            else begin
                logic [31:0] e0;
                e0 = exp_q0.pop_front();
                check_eq("p0_rdata", p0_rdata, e0);
                $display("rd p0 data %h expected %h", p0_rdata, e0);
            end
        end
        if (p1_rvalid) begin
            if (exp_q1.size() == 0) check_eq("p1_unexpected_rvalid", 32'd1, 32'd0);
            else begin
                logic [31:0] e1;
                e1 = exp_q1.pop_front();
                check_eq("p1_rdata", p1_rdata, e1);
                $display("rd p1 data %h expected %h", p1_rdata, e1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic [31:0] a, input logic [1:0] wr,
                          input logic [1:0] rd, input logic [31:0] wd);
        p0_req = req; p0_address = a; p0_memwrite = wr; p0_memread = rd; p0_writedata = wd;
    endtask

    task automatic set_p1(input logic req, input logic [31:0] a, input logic [1:0] wr,
                          input logic [1:0] rd, input logic [31:0] wd);
        p1_req = req; p1_address = a; p1_memwrite = wr; p1_memread = rd; p1_writedata = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {24'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_memwrite, mem_memread}, 32'd0);
        check_eq({tag, "_addr"}, mem_address, 32'd0);
        check_eq({tag, "_wdata"}, mem_writedata, 32'd0);
    endtask

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_g [10];
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        preload = 1'b1;
        reset   = 1'b1;
        set_p0(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        set_p1(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        tick(); tick();
        preload = 1'b0;
        tick();
        check_all_zero("reset");
        check_eq("reset_rdata", p0_rdata | p1_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // p0 lw @0x8, uncontended
        set_p0(1'b1, 32'h8, 2'b00, 2'b01, 32'h0);
        exp_q0.push_back(32'h11223344);
        tick();
        $display("txn p0 lw @00000008 gnt %0b", p0_gnt);
        check_eq("t1_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        check_eq("t1_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        check_eq("t1_memread", {30'd0, mem_memread}, 32'd1);
        check_eq("t1_addr", mem_address, 32'h8);
        p0_req = 1'b0;
        tick();
        check_eq("t1_p0_rvalid", {31'd0, p0_rvalid}, 32'd1);
        check_eq("t1_p1_out", {31'd0, p1_rvalid} | p1_rdata, 32'd0);
        set_p0(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        tick();

        // Simultaneous: p0 sw @0x0, p1 lw @0x0
        set_p0(1'b1, 32'h0, 2'b01, 2'b00, 32'hAABBCCDD);
        set_p1(1'b1, 32'h0, 2'b00, 2'b01, 32'h0);
        exp_q1.push_back(32'hAABBCCDD);
        tick();
        $display("txn p0 sw @00000000 / p1 lw @00000000 gnt %0b%0b", p0_gnt, p1_gnt);
        check_eq("t2_first_gnt", {30'd0, p0_gnt, p1_gnt}, 32'b10);
        p0_req = 1'b0;
        tick();
        check_eq("t2_second_gnt", {30'd0, p0_gnt, p1_gnt}, 32'b01);
        check_eq("t2_mem0", mem[0], 32'hAABBCCDD);
        p1_req = 1'b0;
        tick();
        check_eq("t2_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
        set_p0(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        set_p1(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        tick();

        // Starvation: both held, no-op commands
        p0_req = 1'b1;
        p1_req = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            $display("txn starve cycle %0d gnt p0=%0b p1=%0b", i, p0_gnt, p1_gnt);
            check_eq($sformatf("starve_gnt%0d", i), {30'd0, p0_gnt, p1_gnt},
                     (exp_g[i] == 1) ? 32'b01 : 32'b10);
            tick();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick(); tick();

        // Conflict: p0 sw + lw at once
        set_p0(1'b1, 32'h10, 2'b01, 2'b01, 32'h5555AAAA);
        tick();
        $display("txn p0 sw+lw @00000010 memwrite %b memread %b", mem_memwrite, mem_memread);
        check_eq("t4_gnt", {31'd0, p0_gnt}, 32'd1);
        check_eq("t4_memread", {30'd0, mem_memread}, 32'd0);
        check_eq("t4_memwrite", {30'd0, mem_memwrite}, 32'd1);
        p0_req = 1'b0;
        tick();
        check_eq("t4_no_rvalid", {31'd0, p0_rvalid}, 32'd0);
        check_eq("t4_mem4", mem[4], 32'h5555AAAA);
        set_p0(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        tick();

        // Reset during a G0 store
        set_p0(1'b1, 32'h14, 2'b01, 2'b00, 32'hDEADBEEF);
        tick();
        check_eq("t5_gnt", {31'd0, p0_gnt}, 32'd1);
        check_eq("t5_memwrite_pre", {30'd0, mem_memwrite}, 32'd1);
        reset = 1'b1;
        #1;
        $display("txn reset during p0 sw @00000014 memwrite %b", mem_memwrite);
        check_all_zero("t5_reset");
        p0_req = 1'b0;
        tick();
        check_eq("t5_mem5", mem[5], 32'h01234567);
        check_eq("t5_rdata", p0_rdata | p1_rdata, 32'd0);
        set_p0(1'b0, 32'h0, 2'b00, 2'b00, 32'h0);
        reset = 1'b0;
        tick();
        check_eq("t5_no_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);

        // Idle for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("txn idle cycle %0d", i);
            check_all_zero($sformatf("idle%0d", i));
        end

        check_eq("sb_empty", exp_q0.size() + exp_q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
